// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
// Optional feature macro used by the top: SEVEN_SEG_DIMMING_EN.
package seven_seg_pkg;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH = 7'h40;

    // Active-high glyphs, bit0=a .. bit6=g; non-decimal codes show a dash.
    function automatic seg_t bcd_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD nibble to segment pattern, with output polarity select.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter bit Active_Low = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    seg_t w_seg;

    always_comb begin
        w_seg = bcd_to_seg(i_nibble);
        o_seg = Active_Low ? ~w_seg : w_seg;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with blanking gaps and per-frame input snapshot.
// Optional brightness PWM enabled by defining SEVEN_SEG_DIMMING_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int Digit_Count        = 3,
    parameter int Dwell_Cycles       = 1000,
    parameter int Blank_Cycles       = 16,
    parameter bit Segment_Active_Low = 1'b1,
    parameter bit Digit_Active_Low   = 1'b1
) (
    input  logic                       clk,
    input  logic                       clk_en,
    input  logic                       sync_rst,
    input  logic [Digit_Count*4-1:0]   nibbles_in,
    input  logic [Digit_Count-1:0]     nibbles_valid,
`ifdef SEVEN_SEG_DIMMING_EN
    input  logic [3:0]                 brightness,
`endif
    output logic [6:0]                 segments,
    output logic [Digit_Count-1:0]     digit_select,
    output logic                       frame_done
);

    localparam int MAX_CYC = (Dwell_Cycles > Blank_Cycles) ? Dwell_Cycles : Blank_Cycles;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int IDX_W   = (Digit_Count > 1) ? $clog2(Digit_Count) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(Dwell_Cycles - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(Blank_Cycles - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(Digit_Count - 1);

    localparam logic [6:0]             SEG_OFF  = Segment_Active_Low ? 7'h7F : 7'h00;
    localparam logic [Digit_Count-1:0] DSEL_OFF = Digit_Active_Low ? '1 : '0;

    scan_state_t                r_state;
    logic [CNT_W-1:0]           r_count;
    logic [IDX_W-1:0]           r_index;
    logic [Digit_Count*4-1:0]   r_snap_nib;
    logic [Digit_Count-1:0]     r_snap_vld;
    logic [6:0]                 r_segments;
    logic [Digit_Count-1:0]     r_digit_select;
    logic                       r_frame_done;

    scan_state_t                w_state_next;
    logic [CNT_W-1:0]           w_count_next;
    logic [IDX_W-1:0]           w_index_next;
    logic                       w_snap_capture;
    logic                       w_frame_wrap;
    logic [Digit_Count*4-1:0]   w_snap_nib_next;
    logic [Digit_Count-1:0]     w_snap_vld_next;
    logic [3:0]                 w_cur_nib;
    logic [6:0]                 w_dec_seg;
    logic                       w_pwm_on;
    logic [Digit_Count-1:0]     w_dsel_act;
    logic [6:0]                 w_segments_next;
    logic [Digit_Count-1:0]     w_digit_select_next;

    // Next-state logic: BLANK and DRIVE alternate, index advances after each DRIVE.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count + 1'b1;
        w_index_next   = r_index;
        w_snap_capture = 1'b0;
        w_frame_wrap   = 1'b0;
        case (r_state)
            BLANK: begin
                if (r_count == BLANK_LAST) begin
                    w_state_next   = DRIVE;
                    w_count_next   = '0;
                    w_snap_capture = (r_index == '0);
                end
            end
            DRIVE: begin
                if (r_count == DWELL_LAST) begin
                    w_state_next = BLANK;
                    w_count_next = '0;
                    if (r_index == IDX_LAST) begin
                        w_index_next = '0;
                        w_frame_wrap = 1'b1;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = BLANK;
                w_count_next = '0;
                w_index_next = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they change with the state.
    always_comb begin
        w_snap_nib_next = w_snap_capture ? nibbles_in    : r_snap_nib;
        w_snap_vld_next = w_snap_capture ? nibbles_valid : r_snap_vld;
        w_cur_nib       = w_snap_nib_next[{w_index_next, 2'b00} +: 4];
    end

    seven_seg_decoder #(
        .Active_Low (Segment_Active_Low)
    ) u_decoder (
        .i_nibble (w_cur_nib),
        .o_seg    (w_dec_seg)
    );

`ifdef SEVEN_SEG_DIMMING_EN
    logic [3:0] r_pwm_count;
    logic [3:0] w_pwm_next;

    // PWM restarts at every DRIVE entry; BLANK keeps it at zero.
    always_comb begin
        w_pwm_next = (r_state == BLANK) ? 4'd0 : r_pwm_count + 4'd1;
        w_pwm_on   = (w_pwm_next <= brightness);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_pwm_count <= 4'd0;
        end else if (clk_en) begin
            r_pwm_count <= w_pwm_next;
        end
    end
`else
    assign w_pwm_on = 1'b1;
`endif

    always_comb begin
        w_dsel_act      = '0;
        w_segments_next = SEG_OFF;
        if (w_state_next == DRIVE) begin
            w_segments_next = w_dec_seg;
            if (w_snap_vld_next[w_index_next] && w_pwm_on) begin
                w_dsel_act[w_index_next] = 1'b1;
            end
        end
        w_digit_select_next = Digit_Active_Low ? ~w_dsel_act : w_dsel_act;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state    <= BLANK;
            r_count    <= '0;
            r_index    <= '0;
            r_snap_nib <= '0;
            r_snap_vld <= '0;
        end else if (clk_en) begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_index    <= w_index_next;
            r_snap_nib <= w_snap_nib_next;
            r_snap_vld <= w_snap_vld_next;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_segments     <= SEG_OFF;
            r_digit_select <= DSEL_OFF;
            r_frame_done   <= 1'b0;
        end else if (clk_en) begin
            r_segments     <= w_segments_next;
            r_digit_select <= w_digit_select_next;
            r_frame_done   <= w_frame_wrap;
        end
    end

    assign segments     = r_segments;
    assign digit_select = r_digit_select;
    assign frame_done   = r_frame_done;

endmodule
